clk_en_gen: RTL and testbench

//   Multi-channel, runtime-programmable clock-enable generator; successor to the fixed single divider.

---
 rtl/clk_en_gen_pkg.sv | 26 ++
 rtl/clk_en_chan.sv | 66 ++++++
 rtl/clk_en_gen.sv | 71 +++++++
 tb/tb_clk_en_gen.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg: shared types and helpers for the clk_en_gen slice
//   CNT_W_DEF   default counter/divisor width
//   cnt_t       counter/divisor/phase word
//   ch_t        stored channel index (up to 256 channels)
//   cfg_slot_t  pending divisor update {ch, div[, phase]}
//   norm_div    maps a requested divisor of 0 to 1
//   clamp_phase limits a start phase to the last count of a period
//   Optional macro CLK_EN_GEN_PHASE_EN adds the phase field to cfg_slot_t.
package clk_en_gen_pkg;
    localparam int CNT_W_DEF = 16;
    typedef logic [CNT_W_DEF-1:0] cnt_t;
    typedef logic [7:0] ch_t;
    typedef struct packed {
        ch_t  ch;
        cnt_t div;
`ifdef CLK_EN_GEN_PHASE_EN
        cnt_t phase;
`endif
    } cfg_slot_t;
    function automatic cnt_t norm_div(input cnt_t d);
        return (d == '0) ? cnt_t'(1) : d;
    endfunction
    function automatic cnt_t clamp_phase(input cnt_t p, input cnt_t d);
        return (p > d - cnt_t'(1)) ? d - cnt_t'(1) : p;
    endfunction
endpackage

// File: rtl/clk_en_chan.sv
// clk_en_chan: one counter/divisor channel of clk_en_gen
//   clk, rst   clock, synchronous active-high reset
//   run        channel enable; low holds the counter at its start value
//   restart    reload the start value this edge (sync)
//   load       take ld_div (and ld_phase) as the new divisor (and phase)
//   ld_div     new divisor, already normalised to >= 1
//   ld_phase   new start phase (only with CLK_EN_GEN_PHASE_EN)
//   wrap       combinational: the counter ends its period at this edge
//   clk_en     registered one-cycle enable pulse
module clk_en_chan
    import clk_en_gen_pkg::*;
#(
    parameter cnt_t DEF_DIV = cnt_t'(4)
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    input  logic load,
    input  cnt_t ld_div,
`ifdef CLK_EN_GEN_PHASE_EN
    input  cnt_t ld_phase,
`endif
    output logic wrap,
    output logic clk_en
);
    cnt_t cnt, div, nxt_div, start;
    assign nxt_div = load ? ld_div : div;
`ifdef CLK_EN_GEN_PHASE_EN
    cnt_t phase, nxt_phase;
    assign nxt_phase = load ? ld_phase : phase;
    // Start value follows the divisor/phase that will be in force after this edge.
    assign start = clamp_phase(nxt_phase, nxt_div);
`else
    assign start = '0;
`endif
    // Wrap uses the divisor of the period now ending; a load takes effect for the next one.
    assign wrap = run && (cnt == div - cnt_t'(1));
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            div    <= DEF_DIV;
            clk_en <= 1'b0;
`ifdef CLK_EN_GEN_PHASE_EN
            phase  <= '0;
`endif
        end else begin
            if (load) begin
                div   <= ld_div;
`ifdef CLK_EN_GEN_PHASE_EN
                phase <= ld_phase;
`endif
            end
            if (restart || !run) begin
                cnt    <= start;
                clk_en <= 1'b0;
            end else if (wrap) begin
                cnt    <= '0;
                clk_en <= 1'b1;
            end else begin
                cnt    <= cnt + cnt_t'(1);
                clk_en <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel runtime-programmable clock-enable generator
//   clk, rst    clock, synchronous active-high reset
//   run         per-channel run mask
//   sync        one-cycle pulse restarting every channel counter
//   cfg_valid   divisor update request
//   cfg_ready   pending slot free; transfer on cfg_valid && cfg_ready
//   cfg_ch      target channel (indices >= NUM_CH are accepted and dropped)
//   cfg_div     new divisor, 0 treated as 1
//   cfg_phase   new start phase (only with CLK_EN_GEN_PHASE_EN)
//   clk_en      registered one-cycle enable pulses
//   Optional macro CLK_EN_GEN_PHASE_EN adds per-channel start phase.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 4,
    localparam int CH_W   = $clog2(NUM_CH) | 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] run,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLK_EN_GEN_PHASE_EN
    input  logic [CNT_W-1:0]  cfg_phase,
`endif
    output logic [NUM_CH-1:0] clk_en
);
    cfg_slot_t slot;
    logic slot_full, accept, apply;
    logic [NUM_CH-1:0] wrap, load;
    assign cfg_ready = !slot_full;
    // Out-of-range channels still complete the handshake but never reach the slot.
    assign accept = cfg_valid && !slot_full && ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
    assign apply = |load;
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= 1'b0;
            slot      <= '0;
        end else if (apply) begin
            slot_full <= 1'b0;
        end else if (accept) begin
            slot_full <= 1'b1;
            slot.ch   <= ch_t'(cfg_ch);
            slot.div  <= norm_div(cnt_t'(cfg_div));
`ifdef CLK_EN_GEN_PHASE_EN
            slot.phase <= cnt_t'(cfg_phase);
`endif
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = slot_full && (slot.ch == ch_t'(i)) && (wrap[i] || !run[i] || sync);
        clk_en_chan #(.DEF_DIV(cnt_t'(DEF_DIV))) u_chan (
            .clk     (clk),
            .rst     (rst),
            .run     (run[i]),
            .restart (sync),
            .load    (load[i]),
            .ld_div  (slot.div),
`ifdef CLK_EN_GEN_PHASE_EN
            .ld_phase(slot.phase),
`endif
            .wrap    (wrap[i]),
            .clk_en  (clk_en[i])
        );
    end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed vector bench for clk_en_gen (NUM_CH=4, DEF_DIV=4)
module tb_clk_en_gen;
    logic        clk = 1'b0;
    logic        rst, sync, cfg_valid, cfg_ready;
    logic [3:0]  run, clk_en;
    logic [2:0]  cfg_ch;
    logic [15:0] cfg_div;
`ifdef CLK_EN_GEN_PHASE_EN
    logic [15:0] cfg_phase;
`endif
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  run;
        logic        sync;
        logic        valid;
        logic [2:0]  ch;
        logic [15:0] div;
        logic [15:0] ph;
        logic [3:0]  en;
        logic        rdy;
    } vec_t;
    vec_t vq[$];

    clk_en_gen dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .sync     (sync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
`ifdef CLK_EN_GEN_PHASE_EN
        .cfg_phase(cfg_phase),
`endif
        .clk_en   (clk_en)
    );

    always #5 clk = ~clk;

    function automatic void add(input int r, input int rn, input int s, input int v, input int ch,
                                input int dv, input int ph, input int en, input int rdy);
        vec_t x;
        x.rst = r[0]; x.run = 4'(rn); x.sync = s[0]; x.valid = v[0]; x.ch = 3'(ch);
        x.div = 16'(dv); x.ph = 16'(ph); x.en = 4'(en); x.rdy = rdy[0];
        vq.push_back(x);
    endfunction
    function automatic void r_row();
        add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    endfunction
    function automatic void e(input int rn, input int en, input int rdy);
        add(0, rn, 0, 0, 0, 0, 0, en, rdy);
    endfunction
    function automatic void c(input int rn, input int ch, input int dv, input int ph, input int en, input int rdy);
        add(0, rn, 0, 1, ch, dv, ph, en, rdy);
    endfunction
    function automatic void s(input int rn, input int en, input int rdy);
        add(0, rn, 1, 0, 0, 0, 0, en, rdy);
    endfunction
    function automatic int ph_en(input int k);
        return ((k % 8 == 0) ? 1 : 0) | ((k % 8 == 4) ? 2 : 0) | ((k % 8 == 1) ? 4 : 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst = x.rst; run = x.run; sync = x.sync; cfg_valid = x.valid; cfg_ch = x.ch; cfg_div = x.div;
`ifdef CLK_EN_GEN_PHASE_EN
        cfg_phase = x.ph;
`endif
    endtask

    task automatic wait_pulse(input string name, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!clk_en[3] && n < 10);
        if (!clk_en[3]) chk({name, " timeout"}, 32'(clk_en[3]), 32'd1);
    endtask

    initial begin
        int n;
        // 1: default divisor 4 on ch0
        r_row();
        for (int k = 1; k <= 12; k++) e(1, (k % 4 == 0) ? 1 : 0, 1);
        // 2: div 3 requested at cnt=1, applied at the wrap
        r_row();
        e(1, 0, 1); c(1, 0, 3, 0, 0, 0); e(1, 0, 0); e(1, 1, 1);
        e(1, 0, 1); e(1, 0, 1); e(1, 1, 1); e(1, 0, 1); e(1, 0, 1); e(1, 1, 1);
        // 3: div 0 and div 1 on ch1
        r_row();
        c(0, 1, 0, 0, 0, 0); e(0, 0, 1); e(2, 2, 1); e(2, 2, 1);
        c(2, 1, 1, 0, 2, 0); e(2, 2, 1); e(2, 2, 1); e(0, 0, 1);
        // 4: ch0 div 5, ch2 div 7, sync when ch0 would wrap
        r_row();
        c(0, 0, 5, 0, 0, 0); e(0, 0, 1); c(0, 2, 7, 0, 0, 0); e(0, 0, 1);
        for (int k = 1; k <= 4; k++) e(5, 0, 1);
        s(5, 0, 1);
        for (int j = 1; j <= 10; j++) e(5, ((j % 5 == 0) ? 1 : 0) | ((j % 7 == 0) ? 4 : 0), 1);
        // 5: back-to-back requests, second stalls; ch 7 discarded
        r_row();
        c(1, 0, 2, 0, 0, 0); c(1, 0, 3, 0, 0, 0); c(1, 0, 3, 0, 0, 0); c(1, 0, 3, 0, 1, 1);
        c(1, 0, 3, 0, 0, 0); c(1, 0, 3, 0, 1, 1); c(1, 7, 9, 0, 0, 1); e(1, 0, 1); e(1, 1, 1);
        // reset with a pending slot drops it and restores the default divisor
        c(1, 0, 2, 0, 0, 0); r_row();
        for (int k = 1; k <= 4; k++) e(1, (k % 4 == 0) ? 1 : 0, 1);
        // sync applies the pending slot
        r_row();
        c(1, 0, 2, 0, 0, 0); s(1, 0, 1); e(1, 0, 1); e(1, 1, 1); e(1, 0, 1); e(1, 1, 1);
`ifdef CLK_EN_GEN_PHASE_EN
        // 6: div 8 with phases 0, 4 and 9 (clamped to 7)
        r_row();
        c(0, 0, 8, 0, 0, 0); e(0, 0, 1); c(0, 1, 8, 4, 0, 0); e(0, 0, 1); c(0, 2, 8, 9, 0, 0); e(0, 0, 1);
        for (int k = 1; k <= 16; k++) e(7, ph_en(k), 1);
        s(7, 0, 1);
        for (int j = 1; j <= 8; j++) e(7, ph_en(j), 1);
`endif
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(posedge clk); #1;
            chk($sformatf("row%0d clk_en", i), 32'(clk_en), 32'(vq[i].en));
            chk($sformatf("row%0d cfg_ready", i), 32'(cfg_ready), 32'(vq[i].rdy));
        end
        // hand-written: ch3 div 3 latency and period with bounded waits
        rst = 1'b1; run = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        @(posedge clk); #1;
        rst = 1'b0; cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = 16'd3;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        chk("ch3 slot busy", 32'(cfg_ready), 32'd0);
        @(posedge clk); #1;
        chk("ch3 idle apply", 32'(cfg_ready), 32'd1);
        run = 4'b1000;
        wait_pulse("ch3 first", n);
        chk("ch3 latency", 32'(n), 32'd3);
        wait_pulse("ch3 second", n);
        chk("ch3 period", 32'(n), 32'd3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
